mbist_sequencer: RTL

- March-test engine that owns the raw memory port during self-test.
- Runs a 4-element March sequence over the user region, addresses 0..NUM_WORDS-1.
- Reports each mismatching read as a one-cycle fail pulse to the repair controller's bist_fail_valid/bist_fail_addr inputs.
- When idle, passes the repair controller's remapped functional port through to the memory unchanged.

---
 rtl/mbist_sequencer_if.sv | 38 +++
 rtl/mbist_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mbist_sequencer_if.sv
// Bundle of the MBIST control/status, functional-port and raw-memory signals.
// The slave side is the sequencer; the master side is whatever surrounds it.
interface mbist_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int FAIL_CNT_W = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [FAIL_CNT_W-1:0] fail_count;
    logic                  bist_fail_valid;
    logic [ADDR_WIDTH-1:0] bist_fail_addr;

    logic [ADDR_WIDTH-1:0] func_addr;
    logic [DATA_WIDTH-1:0] func_wdata;
    logic                  func_we;
    logic                  func_en;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output start, func_addr, func_wdata, func_we, func_en, mem_rdata,
        input  busy, done, pass, fail_count, bist_fail_valid, bist_fail_addr,
               mem_addr, mem_wdata, mem_we, mem_en
    );

    modport slave (
        input  start, func_addr, func_wdata, func_we, func_en, mem_rdata,
        output busy, done, pass, fail_count, bist_fail_valid, bist_fail_addr,
               mem_addr, mem_wdata, mem_we, mem_en
    );
endinterface

// File: rtl/mbist_sequencer.sv
// Four-element March engine (w0 / r0,w1 / r1,w0 / r0) over words 0..NUM_WORDS-1.
// Owns the raw memory port while busy; otherwise passes the functional port through.
module mbist_sequencer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 30,
    parameter int FAIL_CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mbist_sequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_M0_W,
        S_M1_R,
        S_M1_C,
        S_M1_W,
        S_M2_R,
        S_M2_C,
        S_M2_W,
        S_M3_R,
        S_M3_C,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] PAT0       = '0;
    localparam logic [DATA_WIDTH-1:0] PAT1       = '1;
    localparam logic [FAIL_CNT_W-1:0] CNT_MAX    = '1;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [FAIL_CNT_W-1:0] fail_cnt_q;
    logic [FAIL_CNT_W-1:0] fail_cnt_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;

    logic                  is_cmp;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  fail_hit;

    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + FAIL_CNT_W'(1);
    endfunction

    // Read data arrives one cycle after the _R state, so compare in the _C state.
    always_comb begin
        is_cmp   = (state_q == S_M1_C) || (state_q == S_M2_C) || (state_q == S_M3_C);
        exp_data = (state_q == S_M2_C) ? PAT1 : PAT0;
        fail_hit = is_cmp && (bus.mem_rdata != exp_data);
        fail_cnt_d = fail_hit ? sat_inc(fail_cnt_q) : fail_cnt_q;
    end

    assign bus.bist_fail_valid = fail_hit;
    assign bus.bist_fail_addr  = fail_hit ? addr_q : '0;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.fail_count      = fail_cnt_q;

    // Functional requests are simply dropped while the test owns the port.
    always_comb begin
        bus.mem_addr  = bus.func_addr;
        bus.mem_wdata = bus.func_wdata;
        bus.mem_we    = bus.func_we;
        bus.mem_en    = bus.func_en;
        if (busy_q) begin
            bus.mem_addr  = addr_q;
            bus.mem_wdata = '0;
            bus.mem_we    = 1'b0;
            bus.mem_en    = 1'b0;
            case (state_q)
                S_M0_W, S_M2_W: begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = PAT0;
                end
                S_M1_W: begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = PAT1;
                end
                S_M1_R, S_M2_R, S_M3_R: begin
                    bus.mem_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            fail_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q    <= S_M0_W;
                        addr_q     <= ADDR_FIRST;
                        fail_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end
                end
                S_M0_W: begin
                    if (addr_q == ADDR_LAST) begin
                        state_q <= S_M1_R;
                        addr_q  <= ADDR_FIRST;
                    end else begin
                        addr_q  <= addr_q + ADDR_ONE;
                    end
                end
                S_M1_R: state_q <= S_M1_C;
                S_M1_C: state_q <= S_M1_W;
                S_M1_W: begin
                    if (addr_q == ADDR_LAST) begin
                        state_q <= S_M2_R;
                        addr_q  <= ADDR_LAST;
                    end else begin
                        state_q <= S_M1_R;
                        addr_q  <= addr_q + ADDR_ONE;
                    end
                end
                S_M2_R: state_q <= S_M2_C;
                S_M2_C: state_q <= S_M2_W;
                S_M2_W: begin
                    if (addr_q == ADDR_FIRST) begin
                        state_q <= S_M3_R;
                        addr_q  <= ADDR_LAST;
                    end else begin
                        state_q <= S_M2_R;
                        addr_q  <= addr_q - ADDR_ONE;
                    end
                end
                S_M3_R: state_q <= S_M3_C;
                S_M3_C: begin
                    if (addr_q == ADDR_FIRST) begin
                        // Final compare may still bump the count, so judge pass on the next value.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_cnt_d == '0);
                    end else begin
                        state_q <= S_M3_R;
                        addr_q  <= addr_q - ADDR_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
